// File: rtl/dsp_result_normalizer.sv
// Normalizes 34-bit DSP partial results into 17-bit radix words
// with serial carry propagation and a 2-entry output FIFO.
module dsp_result_normalizer #(
  parameter int WORD_COUNT = 61,
  parameter int CNT_W      = $clog2(WORD_COUNT + 1)
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [33:0] in_p_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [16:0] out_word_o,
  output logic        out_last_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        overflow_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [17:0]       carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [17:0]       ent0_q, ent0_d;
  logic [17:0]       ent1_q, ent1_d;
  logic [1:0]        fcnt_q, fcnt_d;

  logic              accept;
  logic              pop;
  logic              push;
  logic [17:0]       push_ent;
  logic [34:0]       sum;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      carry_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    accept   = in_valid_i & in_ready_o;
    pop      = out_valid_o & out_ready_i;
    sum      = {1'b0, in_p_i} + {17'b0, carry_q};
    push     = 1'b0;
    push_ent = '0;
    state_d  = state_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          push     = 1'b1;
          push_ent = {1'b0, sum[16:0]};
          carry_d  = sum[34:17];
          cnt_d    = CNT_W'(1);
          ovf_d    = 1'b0;
          state_d  = (WORD_COUNT == 1) ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          push     = 1'b1;
          push_ent = {1'b0, sum[16:0]};
          carry_d  = sum[34:17];
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(WORD_COUNT))
            state_d = FLUSH;
        end
      end
      FLUSH: begin
        // a same-cycle pop frees the slot the carry word needs
        if (fcnt_q != 2'd2 || pop) begin
          push     = 1'b1;
          push_ent = {1'b1, carry_q[16:0]};
          ovf_d    = carry_q[17];
          carry_d  = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10: begin
        if (fcnt_q == 2'd0) ent0_d = push_ent;
        else                ent1_d = push_ent;
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          ent0_d = push_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready_o  = (fcnt_q != 2'd2) && (state_q != FLUSH);
    out_valid_o = (fcnt_q != 2'd0);
    out_word_o  = ent0_q[16:0];
    out_last_o  = ent0_q[17];
    overflow_o  = ovf_q;
    busy_o      = (state_q != IDLE) || (fcnt_q != 2'd0);
  end

endmodule

// File: tb/tb_dsp_result_normalizer.sv
// Scoreboard bench for dsp_result_normalizer; the reference model
// builds each frame as one wide integer and reads its 17-bit digits.
module tb_dsp_result_normalizer;

  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] in_p;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] out_word;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        busy;

  dsp_result_normalizer #(.WORD_COUNT(WC)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .in_p_i      (in_p),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_word_o  (out_word),
    .out_last_o  (out_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .overflow_o  (ovf),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [17:0]  exp_q[$];
  logic [127:0] tot;
  int           widx = 0;
  bit           have_prev = 0;
  bit           exp_ovf = 0;
  int           rdy_mode = 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 1)      out_ready = 1'b1;
      else if (rdy_mode == 2) out_ready = 1'b0;
      else                    out_ready = ($urandom % 4) != 0;
    end
  end

  logic [17:0] held;
  bit          stalled = 0;

  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_head", 64'({out_last, out_word}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'({out_last, out_word}), 64'h3FFFF_0000);
        end else begin
          e = exp_q.pop_front();
          chk("out_entry", 64'({out_last, out_word}), 64'(e));
        end
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held = {out_last, out_word};
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic send(input logic [33:0] p, input bit first);
    int n = 0;
    in_valid = 1'b1;
    in_p = p;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (first && have_prev)
      chk("ovf_hold", 64'(ovf), 64'(exp_ovf));
    if (widx == 0) tot = '0;
    tot = tot + ({94'b0, p} << (17 * widx));
    exp_q.push_back({1'b0, tot[17*widx +: 17]});
    widx++;
    if (widx == WC) begin
      exp_q.push_back({1'b1, tot[17*WC +: 17]});
      exp_ovf = tot[17*WC+17];
      have_prev = 1;
      widx = 0;
    end
    @(negedge clk);
    if (first)
      chk("ovf_clear", 64'(ovf), 64'd0);
  endtask

  task automatic frame(input logic [33:0] a, input logic [33:0] b,
                       input logic [33:0] c, input bit gaps,
                       input bit lat);
    logic [33:0] w[3];
    w[0] = a; w[1] = b; w[2] = c;
    for (int i = 0; i < WC; i++) begin
      send(w[i], i == 0);
      if (i == 0 && lat) begin
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_word", 64'(out_word), 64'(a[16:0]));
      end
      if (gaps && ($urandom % 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 300), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    widx = 0;
    have_prev = 1;
    exp_ovf = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [33:0] rnd_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom % 4)
      0: r = 64'h3_FFFF_FFFF;
      1: r = r;
      2: r = r & 64'h3_FFFF;
      default: r = 64'd0;
    endcase
    return r[33:0];
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_p = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_overflow", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    frame(34'h1, 34'h2, 34'h3, 0, 1);
    drain();
    chk("ovf_small", 64'(ovf), 64'd0);

    frame(34'h3_FFFF_FFFF, 34'h1, 34'h0, 0, 0);
    drain();
    chk("ovf_ripple", 64'(ovf), 64'd0);

    frame(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 0, 0);
    drain();
    chk("ovf_max", 64'(ovf), 64'd1);

    rdy_mode = 2;
    @(negedge clk);
    send(34'h1_2345, 1);
    send(34'h0_0777, 0);
    in_valid = 1'b1;
    in_p = 34'h2_AAAA_5555;
    for (int i = 0; i < 6; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    rdy_mode = 1;
    send(34'h2_AAAA_5555, 0);
    drain();

    rdy_mode = 2;
    @(negedge clk);
    send(34'h3_0000_1234, 1);
    send(34'h3_FFFF_FFFF, 0);
    in_valid = 1'b0;
    do_reset();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rdy_mode = 1;
    frame(34'h5, 34'h0, 34'h0, 0, 1);
    drain();

    frame(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 0, 0);
    frame(34'h1, 34'h2, 34'h3, 0, 0);
    drain();
    chk("b2b_ovf", 64'(ovf), 64'd0);

    rdy_mode = 0;
    for (int f = 0; f < 40; f++)
      frame(rnd_word(), rnd_word(), rnd_word(), 1, 0);
    drain();
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk("final_ovf", 64'(ovf), 64'(exp_ovf));
    chk("final_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
